// File: rtl/id_stage.sv
// id_stage: instruction decode stage of a 5-stage MIPS pipeline.
// Decodes the IF/ID instruction into WB/M/EX control bundles, reads rs/rt
// from a 32x32 register file written by WB, sign-extends the immediate and
// registers everything into the ID/EX latch (flush > hold > load).
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle WB -> read bypass).
module id_stage #(
  parameter logic [5:0] NOP_OPCODE = 6'h3F
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IF_ID_INSTR,
  input  logic [31:0] IF_ID_NPC,
  input  logic        MEM_WB_RegWrite,
  input  logic [4:0]  MEM_WB_WriteReg,
  input  logic [31:0] WB_WriteData,
  input  logic        flush,
  input  logic        hold,
  output logic [1:0]  ID_EX_WB,
  output logic [2:0]  ID_EX_M,
  output logic [3:0]  ID_EX_EX,
  output logic [31:0] ID_EX_NPC,
  output logic [31:0] ID_EX_RD1,
  output logic [31:0] ID_EX_RD2,
  output logic [31:0] ID_EX_IMM,
  output logic [4:0]  ID_EX_RT,
  output logic [4:0]  ID_EX_RD
);

  logic [31:0] regs_r [32];
  logic [5:0]  op_s;
  logic [5:0]  eff_op_s;
  logic [1:0]  wb_s;
  logic [2:0]  m_s;
  logic [3:0]  ex_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [31:0] rd1_s;
  logic [31:0] rd2_s;
  logic [31:0] imm_s;
  logic        wr_en_s;

  assign op_s    = IF_ID_INSTR[31:26];
  assign rs_s    = IF_ID_INSTR[25:21];
  assign rt_s    = IF_ID_INSTR[20:16];
  assign imm_s   = {{16{IF_ID_INSTR[15]}}, IF_ID_INSTR[15:0]};
  assign wr_en_s = MEM_WB_RegWrite && (MEM_WB_WriteReg != 5'd0);

  // Opcode decode: unsupported opcodes are folded onto NOP_OPCODE, which decodes to zero control.
  always_comb begin
    case (op_s)
      6'h00, 6'h23, 6'h2B, 6'h04: eff_op_s = op_s;
      default:                    eff_op_s = NOP_OPCODE;
    endcase
    case (eff_op_s)
      6'h00: begin wb_s = 2'b10; m_s = 3'b000; ex_s = 4'b1100; end
      6'h23: begin wb_s = 2'b11; m_s = 3'b010; ex_s = 4'b0001; end
      6'h2B: begin wb_s = 2'b00; m_s = 3'b001; ex_s = 4'b0001; end
      6'h04: begin wb_s = 2'b00; m_s = 3'b100; ex_s = 4'b0010; end
      default: begin wb_s = 2'b00; m_s = 3'b000; ex_s = 4'b0000; end
    endcase
  end

  // Combinational operand read; $0 is hard-wired to zero, optional WB bypass.
  always_comb begin
    if (rs_s == 5'd0) begin
      rd1_s = 32'd0;
    end else begin
      rd1_s = regs_r[rs_s];
    end
    if (rt_s == 5'd0) begin
      rd2_s = 32'd0;
    end else begin
      rd2_s = regs_r[rt_s];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_en_s && (MEM_WB_WriteReg == rs_s)) begin
      rd1_s = WB_WriteData;
    end else begin
      rd1_s = rd1_s;
    end
    if (wr_en_s && (MEM_WB_WriteReg == rt_s)) begin
      rd2_s = WB_WriteData;
    end else begin
      rd2_s = rd2_s;
    end
`endif
  end

  // Register file write port; writes to $0 are dropped, reset clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (wr_en_s) begin
      regs_r[MEM_WB_WriteReg] <= WB_WriteData;
    end
  end

  // ID/EX pipeline latch: flush zeroes control but loads data, hold freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ID_EX_WB  <= 2'b00;
      ID_EX_M   <= 3'b000;
      ID_EX_EX  <= 4'b0000;
      ID_EX_NPC <= 32'd0;
      ID_EX_RD1 <= 32'd0;
      ID_EX_RD2 <= 32'd0;
      ID_EX_IMM <= 32'd0;
      ID_EX_RT  <= 5'd0;
      ID_EX_RD  <= 5'd0;
    end else if (flush) begin
      ID_EX_WB  <= 2'b00;
      ID_EX_M   <= 3'b000;
      ID_EX_EX  <= 4'b0000;
      ID_EX_NPC <= IF_ID_NPC;
      ID_EX_RD1 <= rd1_s;
      ID_EX_RD2 <= rd2_s;
      ID_EX_IMM <= imm_s;
      ID_EX_RT  <= IF_ID_INSTR[20:16];
      ID_EX_RD  <= IF_ID_INSTR[15:11];
    end else if (!hold) begin
      ID_EX_WB  <= wb_s;
      ID_EX_M   <= m_s;
      ID_EX_EX  <= ex_s;
      ID_EX_NPC <= IF_ID_NPC;
      ID_EX_RD1 <= rd1_s;
      ID_EX_RD2 <= rd2_s;
      ID_EX_IMM <= imm_s;
      ID_EX_RT  <= IF_ID_INSTR[20:16];
      ID_EX_RD  <= IF_ID_INSTR[15:11];
    end
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction Decode stage of the 5-stage pipelined MIPS datapath. Sits directly downstream of the instruction fetch stage and consumes its IF/ID outputs (instruction word and next PC). It decodes the instruction into control bundles, reads two operands from a 32×32 register file written back by the WB stage, and sign-extends the immediate. All results are registered into the ID/EX pipeline latch for the execute stage.

## Interface
Parameters:
- `NOP_OPCODE`, 6'h3F: opcode forced onto unsupported instructions; any opcode decoding as unsupported yields all-zero control.

Ports:
- `clk` in 1: pipeline clock; rising-edge active.
- `rst_n` in 1: asynchronous, active-low reset.
- `IF_ID_INSTR` in 32: instruction from the IF/ID latch.
- `IF_ID_NPC` in 32: PC+4 from the IF/ID latch.
- `MEM_WB_RegWrite` in 1: write-back enable.
- `MEM_WB_WriteReg` in 5: write-back destination register.
- `WB_WriteData` in 32: write-back data.
- `flush` in 1: insert bubble into ID/EX.
- `hold` in 1: freeze ID/EX contents (stall).
- `ID_EX_WB` out 2: {RegWrite, MemtoReg}.
- `ID_EX_M` out 3: {Branch, MemRead, MemWrite}.
- `ID_EX_EX` out 4: {RegDst, ALUOp[1:0], ALUSrc}.
- `ID_EX_NPC` out 32: latched NPC.
- `ID_EX_RD1` / `ID_EX_RD2` out 32: rs / rt operand values.
- `ID_EX_IMM` out 32: sign-extended instr[15:0].
- `ID_EX_RT` / `ID_EX_RD` out 5: instr[20:16] / instr[15:11].

## Operation
- Decode by opcode instr[31:26]. Each entry lists WB / M / EX:
  - R-type 6'h00: 10 / 000 / 1_10_0.
  - lw 6'h23: 11 / 010 / 0_00_1.
  - sw 6'h2B: 00 / 001 / 0_00_1.
  - beq 6'h04: 00 / 100 / 0_01_0.
  - Any other opcode: all zero.
- Register file: 32 entries × 32 bits.
  - Read is combinational on rs = instr[25:21] and rt = instr[20:16].
  - Write occurs on the rising `clk` edge when `MEM_WB_RegWrite`=1 and `MEM_WB_WriteReg`≠0.
  - Register 0 always reads 0; writes to it are ignored.
- Sign extension: IMM = {{16{instr[15]}}, instr[15:0]}.
- ID/EX latch update on the rising edge, by priority:
  - `flush`=1: WB, M and EX bundles load zero; data fields load normally. Flush has priority over `hold`.
  - `hold`=1 (and no flush): all ID/EX outputs retain their values. The register file write still proceeds.
  - Otherwise: all fields load the current decode results.
- `rst_n` low, asynchronously:
  - All ID/EX outputs are cleared to 0.
  - All 32 registers are cleared to 0.
  - Reset asserted mid-operation discards any in-flight latch contents and any pending write.

## Timing
- Latency: one cycle. Inputs sampled at edge N appear on the ID_EX_* outputs after edge N.
- Write-back and decode read in the same cycle to the same register (default build): the latch captures the old value. The new value is visible to reads from the following cycle.
- Write to register 0 together with a read of register 0: the read returns 0.
- `hold` and `flush` are level signals sampled on each rising edge; no handshake.
- Outputs read 0 from reset assertion until the first rising edge after `rst_n` deasserts.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - If `MEM_WB_RegWrite`=1, `MEM_WB_WriteReg`≠0 and it equals rs (or rt), then RD1 (or RD2) is taken from `WB_WriteData` in the same cycle.
  - This implements write-before-read.
- `REGFILE_BYPASS_EN` undefined: no bypass; the old value is latched as described under Timing.

## Test plan
- Reset with `rst_n`=0 mid-stream, then release → all ID_EX_* outputs = 0 and a read of $5 returns 0.
- Write $8=32'hDEADBEEF, then decode `add $3,$8,$8` (32'h01081820) → RD1 = RD2 = 32'hDEADBEEF, EX=4'b1100, WB=2'b10, RD=5'd3.
- Decode `lw $9,-4($8)` (32'h8D09FFFC) → IMM=32'hFFFFFFFC, WB=2'b11, M=3'b010, EX=4'b0001, RT=5'd9.
- Write $0=32'h1234 with `MEM_WB_RegWrite`=1, then read $0 → RD1=0.
- Assert `hold` for 2 cycles while IF_ID_INSTR changes → outputs unchanged. Then assert `flush` together with `hold` → control bundles become 0 and NPC updates.
- Same-cycle write of $4=32'h55 while decoding rs=$4 → RD1=32'h55 with `REGFILE_BYPASS_EN` defined; RD1 = previous $4 value without it.
